// File: rtl/router_pkg.sv
// router_pkg: shared packet types and merge-stage state encoding for the router.
// Contents: packet width and address field bounds, pkt_t, merge_state_t.
package router_pkg;
    localparam int PKT_W   = 9;
    localparam int ADDR_HI = 8;
    localparam int ADDR_LO = 5;
    typedef logic [PKT_W-1:0] pkt_t;
    typedef enum logic {EMPTY, FULL} merge_state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-request round-robin grant with a remembered last winner.
// Ports: clk_i clock; rst_ni sync active-low reset; req0_i/req1_i requests;
//        accept_i a grant is taken this cycle; grant_o index of the winner.
module rr_arb2
    import router_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req0_i,
    input  logic req1_i,
    input  logic accept_i,
    output logic grant_o
);
    logic last_grant_q;
    // Resetting to 1 lets input 0 win the first contention.
    assign grant_o = (req0_i && req1_i) ? !last_grant_q : req1_i;
    always_ff @(posedge clk_i) begin
        if (!rst_ni) last_grant_q <= 1'b1;
        else if (accept_i) last_grant_q <= grant_o;
    end
endmodule

// File: rtl/merge2_arbiter.sv
// merge2_arbiter: merges two valid/ready packet streams into one output register.
// Ports: CLK, _RESET (sync active-low); in0_*/in1_* packet inputs with ready;
//        out_* held packet; sel_* index of the supplying input; cnt0/cnt1
//        wrapping per-input accept counters.
module merge2_arbiter
    import router_pkg::*;
#(
    parameter int W  = PKT_W,
    parameter int CW = 8
) (
    input  logic          CLK,
    input  logic          _RESET,
    input  logic [W-1:0]  in0_data,
    input  logic          in0_valid,
    output logic          in0_ready,
    input  logic [W-1:0]  in1_data,
    input  logic          in1_valid,
    output logic          in1_ready,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          sel_data,
    output logic          sel_valid,
    input  logic          sel_ready,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);
    merge_state_t  state_q;
    logic          out_done_q, sel_done_q, sel_data_q;
    logic [W-1:0]  out_data_q;
    logic [CW-1:0] cnt0_q, cnt1_q;
    logic          full, out_hs, sel_hs, drain, free, grant, accept;

    assign full      = state_q == FULL;
    assign out_valid = full && !out_done_q;
    assign sel_valid = full && !sel_done_q;
    assign out_hs    = out_valid && out_ready;
    assign sel_hs    = sel_valid && sel_ready;
    // Both halves must be consumed (earlier or now) before the register frees.
    assign drain     = full && (out_done_q || out_hs) && (sel_done_q || sel_hs);
    assign free      = !full || drain;
    assign accept    = free && (in0_valid || in1_valid) && _RESET;
    assign in0_ready = free && !grant && _RESET;
    assign in1_ready = free && grant && _RESET;
    assign out_data  = out_data_q;
    assign sel_data  = sel_data_q;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;

    rr_arb2 u_arb (
        .clk_i    (CLK),
        .rst_ni   (_RESET),
        .req0_i   (in0_valid),
        .req1_i   (in1_valid),
        .accept_i (accept),
        .grant_o  (grant)
    );

    always_ff @(posedge CLK) begin
        if (!_RESET) begin
            state_q    <= EMPTY;
            out_done_q <= 1'b0;
            sel_done_q <= 1'b0;
            out_data_q <= '0;
            sel_data_q <= 1'b0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else if (accept) begin
            state_q    <= FULL;
            out_done_q <= 1'b0;
            sel_done_q <= 1'b0;
            out_data_q <= grant ? in1_data : in0_data;
            sel_data_q <= grant;
            if (grant) cnt1_q <= cnt1_q + CW'(1);
            else cnt0_q <= cnt0_q + CW'(1);
        end else if (drain) begin
            state_q    <= EMPTY;
            out_done_q <= 1'b0;
            sel_done_q <= 1'b0;
        end else begin
            out_done_q <= out_done_q || out_hs;
            sel_done_q <= sel_done_q || sel_hs;
        end
    end
endmodule

// File: tb/tb_merge2_arbiter.sv
// tb_merge2_arbiter: scoreboard bench for the two-input round-robin merge stage.
module tb_merge2_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] in0_data = '0, in1_data = '0, out_data;
    logic       in0_valid = 1'b0, in1_valid = 1'b0, in0_ready, in1_ready;
    logic       out_valid, out_ready = 1'b1, sel_data, sel_valid, sel_ready = 1'b1;
    logic [7:0] cnt0, cnt1;
    int         checks = 0, errors = 0;
    logic [8:0] out_exp[$];
    logic       sel_exp[$];

    merge2_arbiter #(.W(9), .CW(8)) dut (
        .CLK(clk), ._RESET(rst_n),
        .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
        .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sel_data(sel_data), .sel_valid(sel_valid), .sel_ready(sel_ready),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: run did not complete, actual still running, required finish");
        $fatal(1, "timeout");
    end

    // Inputs change 1 time unit after posedge, so the negedge sees the values
    // that the next posedge will act on.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (out_exp.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: actual %h required none", out_data);
            end else begin
                logic [8:0] e;
                e = out_exp.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL out_data: actual %h required %h", out_data, e);
                end
            end
        end
        if (rst_n && sel_valid && sel_ready) begin
            checks++;
            if (sel_exp.size() == 0) begin
                errors++;
                $display("FAIL sel_unexpected: actual %0d required none", sel_data);
            end else begin
                logic e;
                e = sel_exp.pop_front();
                if (sel_data !== e) begin
                    errors++;
                    $display("FAIL sel_data: actual %0d required %0d", sel_data, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [8:0] d, input logic s);
        out_exp.push_back(d);
        sel_exp.push_back(s);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        step();
        out_exp.delete();
        sel_exp.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in0_valid = 1'b1;
        in0_data = 9'h055;
        step();
        step();
        checks += 7;
        if (out_valid !== 1'b0 || sel_valid !== 1'b0) begin
            errors++; $display("FAIL rst_valid: actual %b%b required 00", out_valid, sel_valid);
        end
        if (out_data !== 9'h0) begin errors++; $display("FAIL rst_out_data: actual %h required 000", out_data); end
        if (sel_data !== 1'b0) begin errors++; $display("FAIL rst_sel_data: actual %b required 0", sel_data); end
        if (cnt0 !== 8'd0) begin errors++; $display("FAIL rst_cnt0: actual %0d required 0", cnt0); end
        if (cnt1 !== 8'd0) begin errors++; $display("FAIL rst_cnt1: actual %0d required 0", cnt1); end
        if (in0_ready !== 1'b0) begin errors++; $display("FAIL rst_in0_ready: actual %b required 0", in0_ready); end
        if (in1_ready !== 1'b0) begin errors++; $display("FAIL rst_in1_ready: actual %b required 0", in1_ready); end
        in0_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        in0_data = 9'h1A3;
        in0_valid = 1'b1;
        #1;
        checks++;
        if (in0_ready !== 1'b1) begin errors++; $display("FAIL single_ready: actual %b required 1", in0_ready); end
        push(9'h1A3, 1'b0);
        step();
        in0_valid = 1'b0;
        checks += 4;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid: actual %b required 1", out_valid); end
        if (out_data !== 9'h1A3) begin errors++; $display("FAIL single_out_data: actual %h required 1a3", out_data); end
        if (sel_valid !== 1'b1) begin errors++; $display("FAIL single_sel_valid: actual %b required 1", sel_valid); end
        if (sel_data !== 1'b0) begin errors++; $display("FAIL single_sel_data: actual %b required 0", sel_data); end
        step();
        checks += 2;
        if (out_valid !== 1'b0 || sel_valid !== 1'b0) begin
            errors++; $display("FAIL single_drop: actual %b%b required 00", out_valid, sel_valid);
        end
        if (cnt0 !== 8'd1) begin errors++; $display("FAIL single_cnt0: actual %0d required 1", cnt0); end
    endtask

    task automatic test_contention();
        do_reset();
        in0_data = 9'h011;
        in1_data = 9'h122;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic s;
            s = i[0];
            #1;
            checks++;
            if (in0_ready !== !s || in1_ready !== s) begin
                errors++; $display("FAIL rr_ready[%0d]: actual %b%b required %b%b", i, in1_ready, in0_ready, s, !s);
            end
            push(s ? 9'h122 : 9'h011, s);
            step();
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_out_valid[%0d]: actual %b required 1", i, out_valid); end
        end
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        step();
        checks += 2;
        if (cnt0 !== 8'd3 || cnt1 !== 8'd3) begin
            errors++; $display("FAIL rr_counts: actual %0d/%0d required 3/3", cnt0, cnt1);
        end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_idle: actual %b required 0", out_valid); end
    endtask

    task automatic test_backpressure();
        sel_ready = 1'b0;
        in0_data = 9'h0F5;
        in0_valid = 1'b1;
        push(9'h0F5, 1'b0);
        step();
        in0_data = 9'h1C3;
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid0: actual %b required 1", out_valid); end
        if (in0_ready !== 1'b0) begin errors++; $display("FAIL bp_ready0: actual %b required 0", in0_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks += 3;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_out_valid[%0d]: actual %b required 0", k, out_valid); end
            if (sel_valid !== 1'b1 || sel_data !== 1'b0) begin
                errors++; $display("FAIL bp_sel_hold[%0d]: actual v%b d%b required v1 d0", k, sel_valid, sel_data);
            end
            if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
                errors++; $display("FAIL bp_ready[%0d]: actual %b%b required 00", k, in1_ready, in0_ready);
            end
        end
        sel_ready = 1'b1;
        #1;
        checks++;
        if (in0_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: actual %b required 1", in0_ready); end
        push(9'h1C3, 1'b0);
        step();
        in0_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 9'h1C3) begin
            errors++; $display("FAIL bp_next: actual v%b %h required v1 1c3", out_valid, out_data);
        end
        step();
    endtask

    task automatic test_lone_in1();
        do_reset();
        in1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in1_data = 9'h100 + 9'(i);
            #1;
            checks++;
            if (in1_ready !== 1'b1) begin errors++; $display("FAIL lone_ready[%0d]: actual %b required 1", i, in1_ready); end
            push(9'h100 + 9'(i), 1'b1);
            step();
        end
        in1_valid = 1'b0;
        step();
        checks++;
        if (cnt1 !== 8'd4 || cnt0 !== 8'd0) begin
            errors++; $display("FAIL lone_counts: actual %0d/%0d required 0/4", cnt0, cnt1);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        in0_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in0_data = 9'(i * 7);
            push(9'(i * 7), 1'b0);
            step();
            if (i == 254) begin
                checks++;
                if (cnt0 !== 8'd255) begin errors++; $display("FAIL wrap_pre: actual %0d required 255", cnt0); end
            end
        end
        in0_valid = 1'b0;
        step();
        checks++;
        if (cnt0 !== 8'd0) begin errors++; $display("FAIL wrap_cnt0: actual %0d required 0", cnt0); end
        in0_data = 9'h155;
        in0_valid = 1'b1;
        push(9'h155, 1'b0);
        step();
        in0_valid = 1'b0;
        step();
        checks++;
        if (cnt0 !== 8'd1) begin errors++; $display("FAIL wrap_after: actual %0d required 1", cnt0); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        sel_ready = 1'b0;
        in1_data = 9'h0C7;
        in1_valid = 1'b1;
        step();
        in1_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_full: actual %b required 1", out_valid); end
        rst_n = 1'b0;
        step();
        checks += 2;
        if (out_valid !== 1'b0 || sel_valid !== 1'b0) begin
            errors++; $display("FAIL mid_valid: actual %b%b required 00", out_valid, sel_valid);
        end
        if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
            errors++; $display("FAIL mid_counts: actual %0d/%0d required 0/0", cnt0, cnt1);
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        sel_ready = 1'b1;
        in0_data = 9'h0AA;
        in1_data = 9'h1BB;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        #1;
        checks++;
        if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
            errors++; $display("FAIL mid_grant: actual %b%b required 01", in1_ready, in0_ready);
        end
        push(9'h0AA, 1'b0);
        step();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_lone_in1();
        test_wrap();
        test_reset_mid();
        step();
        checks++;
        if (out_exp.size() != 0 || sel_exp.size() != 0) begin
            errors++; $display("FAIL leftover: actual %0d/%0d required 0/0", out_exp.size(), sel_exp.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/merge2_arbiter.md
Name: merge2_arbiter

Overview:
- Downstream neighbour of the 1-to-2 address decoder. It merges two 9-bit packet streams arriving from two decoder outputs into one router output port.
- Arbitration is round-robin between the two inputs. Each accepted packet is held in a one-entry output register.
- The packet leaves on Out. The winning input index is reported on a separate 1-bit Sel channel, mirroring the decoder's S channel.
- Per-input packet counters are provided for debug and verification.

Parameters:
- W, 9, packet width. Bits [8:5] are the destination address and bits [4:0] are the payload; the block does not interpret them.
- CW, 8, width of each per-input packet counter.

Ports:
- CLK  input  1  clock; all state changes on the rising edge
- _RESET  input  1  reset, synchronous, active-low
- in0_data  input  W  packet on input 0
- in0_valid  input  1  input 0 presents a packet
- in0_ready  output  1  input 0 packet accepted this cycle when in0_valid && in0_ready
- in1_data  input  W  packet on input 1
- in1_valid  input  1  input 1 presents a packet
- in1_ready  output  1  input 1 packet accepted this cycle when in1_valid && in1_ready
- out_data  output  W  held packet
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer takes out_data
- sel_data  output  1  index of the input that supplied the held packet
- sel_valid  output  1  sel_data is valid
- sel_ready  input  1  consumer takes sel_data
- cnt0  output  CW  packets accepted from input 0, wraps modulo 2^CW
- cnt1  output  CW  packets accepted from input 1, wraps modulo 2^CW

Behaviour:
- Reset (_RESET=0 sampled at a rising edge):
  - state=EMPTY, out_valid=0, sel_valid=0, out_data=0, sel_data=0, cnt0=0, cnt1=0.
  - last_grant=1, so input 0 wins the first contention.
  - in0_ready=in1_ready=0 while _RESET=0.
  - Reset asserted mid-operation discards the held packet and its unconsumed halves. Reset has priority over every other event on that edge.
- State machine, states EMPTY and FULL, plus two done flags out_done and sel_done:
  - EMPTY: out_valid=sel_valid=0.
  - FULL: out_valid=!out_done and sel_valid=!sel_done.
- Channel consumption:
  - An Out handshake (out_valid && out_ready) sets out_done. A Sel handshake sets sel_done.
  - Both handshakes may occur in the same cycle or in any order across cycles.
- drain = FULL && (out_done || (out_valid && out_ready)) && (sel_done || (sel_valid && sel_ready)).
- free = EMPTY || drain.
- Grant, combinational:
  - Only in0_valid: grant input 0.
  - Only in1_valid: grant input 1.
  - Both valid: grant !last_grant.
  - inX_ready = free && grant==X && _RESET.
- On acceptance:
  - Register loads data and sel_data=X, state=FULL, done flags clear, last_grant=X, cntX increments.
  - Latency is one cycle: packet accepted at edge N is on out_data with out_valid=1 after edge N.
- Drain without a new acceptance: state returns to EMPTY, done flags clear, outputs drop valid after the edge.
- Drain and acceptance in the same cycle: the register reloads and stays FULL. Full throughput is 1 packet per cycle when both consumers stay ready.
- Back-pressure: while FULL and not draining, both inX_ready=0. out_data, sel_data and the asserted valids hold stable; inputs are never dropped.
- Fairness: under continuous contention the grants strictly alternate 0,1,0,1... A lone requester is granted every free cycle regardless of last_grant.
- Counters wrap from 2^CW-1 to 0 with no saturation and no flag.
- No combinational path from inX_valid to out_valid. The ready outputs depend combinationally on out_ready and sel_ready.

Decomposition:
- Shared package (router_pkg):
  - PKT_W=9, ADDR_HI=8, ADDR_LO=5.
  - Typedef pkt_t = logic [PKT_W-1:0].
  - Enum merge_state_t {EMPTY, FULL}.
- One sub-module, rr_arb2: the two-request round-robin grant logic, holding last_grant and updating it on accept. Everything else stays in merge2_arbiter.

Test Plan:
- Reset, then in0 sends 9'h1A3 with out_ready=sel_ready=1 → after 1 edge out_data=9'h1A3, out_valid=1, sel_data=0, sel_valid=1; next edge both valids drop; cnt0=1.
- in0 and in1 both valid continuously, consumers always ready, 6 cycles → sel_data sequence 0,1,0,1,0,1, one packet per cycle, cnt0=cnt1=3.
- Held packet, out_ready=1 and sel_ready=0 for 3 cycles, then sel_ready=1 → out_valid falls after the first edge; sel_valid stays 1 with sel_data stable; inX_ready=0 throughout; new accept only in the cycle sel completes.
- Only in1 valid for 4 packets after an in1 grant → all 4 granted to in1 back-to-back; cnt1=4.
- Drive 256 in0 packets with CW=8 → cnt0 wraps to 0; forwarding continues unaffected.
- _RESET=0 while FULL with out_ready=0 → after the edge out_valid=sel_valid=0, counters 0, next contention granted to in0.
